// File: rtl/rk_kbd_pkg.sv
// Shared encodings and types for the RK keyboard matrix write path
// and the scripted auto-typing sequencer.
package rk_kbd_pkg;

   localparam logic [7:0] SCR_END  = 8'hFF;
   localparam logic [7:0] SCR_WAIT = 8'h00;
   localparam logic [3:0] ROW_NONE = 4'hF;

   typedef struct packed {
      logic       press;
      logic [2:0] col;
      logic [3:0] row;
   } key_ev_t;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      FETCH,
      ROMWAIT,
      EXEC,
      DELAY
   } state_e;

endpackage

// File: rtl/rk_key_sched_if.sv
// Signal bundle around the key-event scheduler: live key input, script control,
// script ROM port and the matrix write port.
interface rk_key_sched_if #(
   parameter int unsigned AW = 6
);
   logic          live_valid;
   logic          live_press;
   logic [2:0]    live_col;
   logic [3:0]    live_row;
   logic          start;
   logic [AW-1:0] start_addr;
   logic          abort;
   logic [AW-1:0] rom_addr;
   logic [7:0]    rom_data;
   logic          kw_valid;
   logic          kw_press;
   logic [2:0]    kw_col;
   logic [3:0]    kw_row;
   logic          clear_all;
   logic          busy;
   logic          done;
   logic          live_dropped;

   modport master (
      input  live_valid, live_press, live_col, live_row,
      input  start, start_addr, abort, rom_data,
      output rom_addr, kw_valid, kw_press, kw_col, kw_row,
      output clear_all, busy, done, live_dropped
   );

   modport slave (
      output live_valid, live_press, live_col, live_row,
      output start, start_addr, abort, rom_data,
      input  rom_addr, kw_valid, kw_press, kw_col, kw_row,
      input  clear_all, busy, done, live_dropped
   );
endinterface

// File: rtl/rk_tick_timer.sv
// Loadable down-counter that paces script events; zero is high once the
// count has run out and stays high until the next load.
module rk_tick_timer #(
   parameter int unsigned TICK_DIV = 3500000
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   output logic zero
);
   localparam int unsigned CW = $clog2(TICK_DIV);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= CW'(TICK_DIV - 1);
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/rk_key_sched.sv
// Owns the keyboard matrix write port: passes live PS/2 key events through while
// idle and plays a ROM byte script paced by a tick timer while busy.
module rk_key_sched
   import rk_kbd_pkg::*;
#(
   parameter int unsigned TICK_DIV = 3500000,
   parameter int unsigned AW       = 6
) (
   input  logic           clk,
   input  logic           reset,
   rk_key_sched_if.master bus
);
   state_e        state_q, state_d;
   logic [AW-1:0] ptr_q, ptr_d;
   logic [AW-1:0] rom_addr_q, rom_addr_d;
   logic          wrap_q, wrap_d;
   logic          clear_q, clear_d;
   logic          done_q, done_d;
   logic          drop_q, drop_d;
   logic          live_wr_q, live_wr_d;
   key_ev_t       live_ev_q, live_ev_d;
   key_ev_t       live_ev, rom_ev;
   logic          live_mapped;
   logic          exec_wr;
   logic          tmr_load, tmr_zero;

   rk_tick_timer #(
      .TICK_DIV(TICK_DIV)
   ) u_timer (
      .clk  (clk),
      .reset(reset),
      .load (tmr_load),
      .zero (tmr_zero)
   );

   assign live_ev     = {bus.live_press, bus.live_col, bus.live_row};
   assign rom_ev      = key_ev_t'(bus.rom_data);
   assign live_mapped = bus.live_valid && (bus.live_row != ROW_NONE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         rom_addr_q <= '0;
         wrap_q     <= 1'b0;
         clear_q    <= 1'b0;
         done_q     <= 1'b0;
         drop_q     <= 1'b0;
         live_wr_q  <= 1'b0;
         live_ev_q  <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         rom_addr_q <= rom_addr_d;
         wrap_q     <= wrap_d;
         clear_q    <= clear_d;
         done_q     <= done_d;
         drop_q     <= drop_d;
         live_wr_q  <= live_wr_d;
         live_ev_q  <= live_ev_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      rom_addr_d = rom_addr_q;
      wrap_d     = wrap_q;
      clear_d    = 1'b0;
      done_d     = 1'b0;
      drop_d     = live_mapped && (state_q != IDLE);
      live_wr_d  = 1'b0;
      live_ev_d  = live_ev_q;
      exec_wr    = 1'b0;
      tmr_load   = 1'b0;

      if (state_q != IDLE && bus.abort) begin
         state_d = IDLE;
         clear_d = 1'b1;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (live_mapped) begin
                  live_wr_d = 1'b1;
                  live_ev_d = live_ev;
               end
               if (bus.start && !bus.abort) begin
                  state_d = CLEAR;
                  ptr_d   = bus.start_addr;
                  wrap_d  = 1'b0;
                  // A live write already owns the next cycle; clear one cycle later.
                  clear_d = !live_mapped;
               end
            end
            CLEAR: begin
               if (clear_q) begin
                  state_d = FETCH;
               end else begin
                  clear_d = 1'b1;
               end
            end
            FETCH: begin
               rom_addr_d = ptr_q;
               state_d    = ROMWAIT;
            end
            ROMWAIT: begin
               state_d = EXEC;
            end
            EXEC: begin
               if (bus.rom_data == SCR_END) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  exec_wr  = (bus.rom_data != SCR_WAIT) && (rom_ev.row != ROW_NONE);
                  ptr_d    = ptr_q + 1'b1;
                  wrap_d   = (ptr_q == '1);
                  tmr_load = 1'b1;
                  state_d  = DELAY;
               end
            end
            DELAY: begin
               if (tmr_zero) begin
                  if (wrap_q) begin
                     done_d  = 1'b1;
                     state_d = IDLE;
                  end else begin
                     state_d = FETCH;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Script writes come straight from the ROM byte in EXEC; live writes are registered.
   assign bus.kw_valid     = exec_wr | live_wr_q;
   assign bus.kw_press     = exec_wr ? rom_ev.press : live_ev_q.press;
   assign bus.kw_col       = exec_wr ? rom_ev.col : live_ev_q.col;
   assign bus.kw_row       = exec_wr ? rom_ev.row : live_ev_q.row;
   assign bus.rom_addr     = rom_addr_q;
   assign bus.clear_all    = clear_q;
   assign bus.busy         = (state_q != IDLE);
   assign bus.done         = done_q;
   assign bus.live_dropped = drop_q;

endmodule

// File: doc/rk_key_sched.md
Name: rk_key_sched

Overview:
Key-event scheduler that owns the write port of the RK keyboard matrix (keystate rows 0..10, columns 0..7).
It arbitrates between live decoded PS/2 key events and a scripted auto-typing sequencer.
The sequencer reads a byte script from an external ROM and paces its events on a programmable tick.
It sits between the PS/2 decoder and the keyboard matrix register, and is driven by the reset-key and download-done logic.

Parameters:
TICK_DIV, 3500000, clocks per script tick (minimum 2).
AW, 6, script ROM address width.

Ports:
clk  in  1  system clock; the only clock.
reset  in  1  synchronous, active-high reset.
live_valid  in  1  one-cycle strobe: decoded PS/2 key event.
live_press  in  1  1 = press, 0 = release.
live_col  in  3  matrix column.
live_row  in  4  matrix row; 4'hF = unmapped key.
start  in  1  one-cycle request to run the script at start_addr.
start_addr  in  AW  first script byte address.
abort  in  1  one-cycle request to stop the script.
rom_addr  out  AW  script ROM address; registered.
rom_data  in  8  script byte; valid exactly 1 cycle after rom_addr changes.
kw_valid  out  1  one-cycle matrix write strobe.
kw_press  out  1  value to write.
kw_col  out  3  column of the write.
kw_row  out  4  row of the write.
clear_all  out  1  one-cycle strobe: matrix clears all 11 rows.
busy  out  1  high while the script runs (all states except IDLE).
done  out  1  one-cycle strobe: script reached an end byte.
live_dropped  out  1  one-cycle strobe: live event discarded.

Behaviour:
- Reset: state IDLE, tick counter 0, pointer 0. rom_addr=0, kw_*=0, clear_all=0, busy=0, done=0, live_dropped=0.
- Script byte encoding:
  - 8'hFF: end of script.
  - 8'h00: wait one tick.
  - Otherwise {press[7], col[6:4], row[3:0]}; row 4'hF is treated as a wait.
- IDLE:
  - A live_valid with live_row != F produces kw_valid on the next cycle (latency 1), carrying live_press/col/row.
  - live_row == F is ignored with no write and no drop.
  - start moves to CLEAR and latches pointer = start_addr.
- CLEAR: clear_all=1 for one cycle, then FETCH.
- FETCH: rom_addr <= pointer, then ROMWAIT.
- ROMWAIT: one cycle for ROM latency, then EXEC.
- EXEC (rom_data is valid):
  - FF: done=1, go to IDLE.
  - 00 or row F: pointer+1, go to DELAY.
  - Otherwise: kw_valid=1 with the decoded fields, pointer+1, go to DELAY.
- DELAY:
  - The counter loads TICK_DIV-1 on entry and decrements each cycle.
  - At 0: if pointer wrapped to 0 in EXEC, treat it as end (done=1, IDLE); otherwise go to FETCH.
  - Each script event therefore takes TICK_DIV+3 clocks.
- Live events while busy: discarded, live_dropped=1 the following cycle, no kw_valid.
- abort in any non-IDLE state: next cycle clear_all=1, go to IDLE, done stays 0. abort in IDLE is ignored.
- start while busy is ignored.
- start and abort in the same cycle: abort wins. From IDLE this means no script starts and there is no clear_all.
- live_valid and start in the same IDLE cycle: the live event is written (kw_valid next cycle) and CLEAR follows on that same cycle.
- kw_valid and clear_all are never asserted in the same cycle.
- Reset mid-script: immediate return to IDLE with all outputs at reset values. No clear_all is issued; the matrix has its own reset.

Decomposition:
- Shared package rk_kbd_pkg holds:
  - SCR_END=8'hFF and SCR_WAIT=8'h00;
  - ROW_NONE=4'hF;
  - a packed struct key_ev_t {press, col[2:0], row[3:0]};
  - the state enum {IDLE, CLEAR, FETCH, ROMWAIT, EXEC, DELAY}.
- One sub-module: rk_tick_timer, a loadable down-counter with a zero flag, parameterised by TICK_DIV.

Test Plan:
All scenarios use TICK_DIV=4.
1. Idle passthrough: live_valid, press=1, col=2, row=6 → next cycle kw_valid=1, kw_press=1, kw_col=2, kw_row=6. Then row=F → no kw_valid, no live_dropped.
2. Script run:
   - ROM[5..8] = 8'hA6, 8'h26, 8'h00, 8'hFF; start_addr=5.
   - Expected: clear_all one cycle after start; kw_valid (1,2,6) then (0,2,6) spaced 7 clocks apart; done exactly 15 clocks after the second write; busy falls with done.
3. Live during script: live_valid pulsed while busy → live_dropped=1 next cycle, no kw_valid for it, script timing unchanged.
4. Abort: abort during the DELAY after the first write → clear_all next cycle, busy=0, done=0; later live events pass through again.
5. Collisions:
   - start+abort in IDLE → stays IDLE, no clear_all.
   - start while busy → ignored; pointer sequence unchanged.
6. Wrap and reset:
   - With AW=2 and ROM = 8'h12 at all 4 addresses, start_addr=3 → one write, then done on wrap.
   - reset asserted in ROMWAIT → all outputs 0 on the next cycle, state IDLE.
